uart_rx_buf: RTL and testbench
==============================

Name: uart_rx_buf

Overview:
Synthesizable 8N1 UART receiver with a receive FIFO. It sits directly downstream of the SoC UART transmit line (RsTx). It decodes serial frames and buffers the bytes for a consumer: a bench checker, or the debug subsystem. It is the hardware equivalent of the bench terminal model, with framing, overrun and break detection added.

Parameters:
DEPTH, 16, FIFO entries; power of two, range 2..256
PSW, 16, prescaler width in bits

Ports:
HCLK  in  1  clock
HRESET  in  1  synchronous reset, active-high
en  in  1  receiver enable
prescale  in  PSW  16x sample tick every prescale+1 HCLK cycles
rx  in  1  serial line; asynchronous; idle high
rd  in  1  pop head entry
clr_err  in  1  clear sticky error flags
rdata  out  8  FIFO head byte; valid when empty=0
empty  out  1  FIFO empty
full  out  1  FIFO full
level  out  $clog2(DEPTH+1)  entry count
overrun  out  1  sticky: byte dropped because the FIFO was full
frame_err  out  1  sticky: stop bit sampled low
irq  out  1  ~empty | overrun | frame_err

Behaviour:
- Interface: one clock, HCLK. Reset HRESET is synchronous and active-high.
- Reset values: state IDLE, FIFO empty, level=0, empty=1, full=0, overrun=0, frame_err=0, irq=0, rdata=0.
- Reset asserted mid-frame aborts the frame; no partial byte is stored.
- Input conditioning:
  - rx passes through a 2-FF synchronizer, reset to 1; rxs is the synchronized value.
  - tick is asserted when the prescaler counter reaches prescale; the counter then reloads to 0.
  - The prescaler is held at 0 while in IDLE, so the start bit is aligned.
- State machine, with a 4-bit tick counter tc and a 3-bit bit index:
  - IDLE: rxs=0 and en=1 -> START, with tc=0.
  - START: on tick 8, sample rxs. If rxs=1 (glitch) -> IDLE. If rxs=0 -> DATA, with tc=0.
  - DATA: every 16th tick, sample rxs into the shift register LSB-first. After the 8th bit -> STOP.
  - STOP: on the 16th tick, sample rxs.
    - rxs=1: push the byte -> IDLE.
    - rxs=0: discard the byte, set frame_err -> BREAK.
  - BREAK: wait for rxs=1 -> IDLE. This prevents a held-low line from producing repeated frames.
- en=0 forces IDLE on the next cycle and aborts any frame in progress. The FIFO and flags are retained.
- Latency: at prescale=0 (16 clk/bit), the push occurs 1 cycle after the stop sample. The stop sample falls at 152 ticks after IDLE exit.
- FIFO behaviour:
  - Show-ahead: rdata = mem[rptr] (combinational) whenever empty=0.
  - rd while empty: ignored; pointers and level are unchanged.
  - Push while full and rd=0: byte dropped, overrun set.
  - Push while full and rd=1 in the same cycle: both happen; level is unchanged; no overrun.
  - Push while empty and rd=1: the push happens; the rd is ignored.
  - Pointers are log2(DEPTH)+1 bits and wrap naturally.
  - full = level==DEPTH.
- Flags:
  - clr_err clears overrun and frame_err.
  - A set event and clr_err in the same cycle: set wins.
- irq is combinational from registers only.

Optional Feature:
- Macro: UART_RX_PARITY_EN.
- Defined:
  - Adds input parity_odd (1 bit) and output parity_err (sticky, reset 0, cleared by clr_err, included in irq).
  - Adds state PARITY between DATA and STOP; it samples on the 16th tick.
  - Parity check: XOR of the 8 data bits and the parity bit must equal parity_odd.
  - On mismatch: set parity_err and discard the byte. STOP is still checked.
- Undefined: 8N1 only. No parity_odd or parity_err ports exist.

Decomposition:
- Package uart_rx_pkg holds:
  - the state enum: IDLE, START, DATA, PARITY, STOP, BREAK;
  - constants: OVERSAMPLE=16, MID_TICK=8, DATA_BITS=8.
- Sub-module sync_fifo, parameterized by DEPTH and WIDTH=8:
  - inputs: push, pop, wdata;
  - outputs: rdata, empty, full, level;
  - owns the simultaneous push/pop rules.
- The top module holds the synchronizer, prescaler, FSM and flags.

Test Plan:
- Single byte: prescale=0, drive frame 0x41 at 16 clk/bit -> empty falls 1 cycle after the stop sample; rdata=0x41; level=1; irq=1. Pulse rd -> empty=1, irq=0.
- Glitch rejection: rx low for 5 cycles, then high; prescale=0 -> state returns to IDLE; level stays 0; no flags set.
- Overrun at boundary: DEPTH=16, send 0x00..0x10 (17 bytes) with no rd -> level=16, full=1, overrun=1. Pop 16 times -> bytes 0x00..0x0F in order. Then repeat with rd asserted on the 17th push cycle -> overrun stays 0, level=16.
- Framing/break: send 0x55 with stop=0, hold rx low for 400 cycles -> frame_err=1, no push, no further frames. Release rx, send 0xA5 -> rdata=0xA5. clr_err pulse -> frame_err=0.
- Reset/enable mid-frame: assert HRESET during DATA bit 4 -> all outputs at reset values next cycle. Repeat with en=0 -> FIFO contents kept; the aborted byte is absent.
- Baud scaling: prescale=9 (160 clk/bit), send 0xC3 -> rdata=0xC3. With UART_RX_PARITY_EN defined and parity_odd=0, send 0xC3 with parity bit 1 -> parity_err=1, byte discarded.

Source files
------------

// File: rtl/uart_rx_pkg.sv
// uart_rx_pkg: receiver state encoding and frame constants shared by
// the uart_rx_buf top and its testable pieces.
package uart_rx_pkg;

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
      PARITY,
      STOP,
      BREAK
   } rx_state_e;

   localparam int OVERSAMPLE = 16;
   localparam int MID_TICK   = 8;
   localparam int DATA_BITS  = 8;

   // Tick-counter and bit-index values at which a sample is taken.
   localparam logic [3:0] TC_MID   = 4'(MID_TICK - 1);
   localparam logic [3:0] TC_LAST  = 4'(OVERSAMPLE - 1);
   localparam logic [2:0] BIT_LAST = 3'(DATA_BITS - 1);

endpackage

// File: rtl/sync_fifo.sv
// sync_fifo: show-ahead synchronous FIFO, DEPTH a power of two.
// Ports: clk, rst (sync, high), push/wdata in, pop in,
//        rdata (head, 0 when empty), empty, full, level out.
module sync_fifo
   import uart_rx_pkg::*;
#(
   parameter int DEPTH = 16,
   parameter int WIDTH = 8
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         push,
   input  logic                         pop,
   input  logic [WIDTH-1:0]             wdata,
   output logic [WIDTH-1:0]             rdata,
   output logic                         empty,
   output logic                         full,
   output logic [$clog2(DEPTH+1)-1:0]   level
);

   localparam int AW = $clog2(DEPTH);
   localparam int LW = $clog2(DEPTH + 1);

   logic [AW:0]      wptr_q, wptr_d;
   logic [AW:0]      rptr_q, rptr_d;
   logic [WIDTH-1:0] mem_q [DEPTH];
   logic             do_push;
   logic             do_pop;

   // Pointers carry one extra bit so full and empty differ.
   assign empty = (wptr_q == rptr_q);
   assign level = LW'(wptr_q - rptr_q);
   assign full  = (level == LW'(DEPTH));
   assign rdata = empty ? '0 : mem_q[rptr_q[AW-1:0]];

   // A pop on an empty FIFO is ignored; a push into a full FIFO only
   // lands when a real pop frees the slot in the same cycle.
   assign do_pop  = pop & ~empty;
   assign do_push = push & (~full | do_pop);

   assign wptr_d = wptr_q + {{AW{1'b0}}, do_push};
   assign rptr_d = rptr_q + {{AW{1'b0}}, do_pop};

   always_ff @(posedge clk) begin
      if (rst) begin
         wptr_q <= '0;
         rptr_q <= '0;
      end else begin
         wptr_q <= wptr_d;
         rptr_q <= rptr_d;
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) begin
         mem_q[wptr_q[AW-1:0]] <= wdata;
      end
   end

endmodule

// File: rtl/uart_rx_buf.sv
// uart_rx_buf: 8N1 UART receiver (16x oversampling) feeding a FIFO,
// with sticky overrun / framing flags and a level-style irq.
// Ports: HCLK, HRESET (sync, high), en, prescale, rx (async line),
//        rd (pop), clr_err; rdata, empty, full, level, overrun,
//        frame_err, irq.
// Macro UART_RX_PARITY_EN adds parity_odd in and parity_err out.
module uart_rx_buf
   import uart_rx_pkg::*;
#(
   parameter int DEPTH = 16,
   parameter int PSW   = 16
) (
   input  logic                       HCLK,
   input  logic                       HRESET,
   input  logic                       en,
   input  logic [PSW-1:0]             prescale,
   input  logic                       rx,
   input  logic                       rd,
   input  logic                       clr_err,
`ifdef UART_RX_PARITY_EN
   input  logic                       parity_odd,
   output logic                       parity_err,
`endif
   output logic [7:0]                 rdata,
   output logic                       empty,
   output logic                       full,
   output logic [$clog2(DEPTH+1)-1:0] level,
   output logic                       overrun,
   output logic                       frame_err,
   output logic                       irq
);

   logic           rx_meta_q;
   logic           rxs_q;
   logic [PSW-1:0] pcnt_q, pcnt_d;
   logic           tick;
   rx_state_e      state_q, state_d;
   logic [3:0]     tc_q, tc_d;
   logic [2:0]     bit_q, bit_d;
   logic [7:0]     shift_q, shift_d;
   logic           push_q, push_d;
   logic           bad_q, bad_d;
   logic           fe_set;
   logic           ovr_set;
   logic           overrun_q, overrun_d;
   logic           frame_err_q, frame_err_d;
`ifdef UART_RX_PARITY_EN
   logic           pe_set;
   logic           parity_err_q, parity_err_d;
`endif

   // Prescaler is parked at 0 in IDLE so the first tick of a frame
   // lands a fixed distance after the start edge.
   always_comb begin
      tick   = (state_q != IDLE) && (pcnt_q == prescale);
      pcnt_d = pcnt_q + PSW'(1);
      if (state_q == IDLE || tick) begin
         pcnt_d = '0;
      end
   end

   always_comb begin
      state_d = state_q;
      tc_d    = tc_q;
      bit_d   = bit_q;
      shift_d = shift_q;
      bad_d   = bad_q;
      push_d  = 1'b0;
      fe_set  = 1'b0;
`ifdef UART_RX_PARITY_EN
      pe_set  = 1'b0;
`endif
      unique case (state_q)
         IDLE: begin
            if (en && !rxs_q) begin
               state_d = START;
               tc_d    = '0;
            end
         end
         START: begin
            if (tick) begin
               tc_d = tc_q + 4'd1;
               if (tc_q == TC_MID) begin
                  tc_d    = '0;
                  bit_d   = '0;
                  bad_d   = 1'b0;
                  state_d = rxs_q ? IDLE : DATA;
               end
            end
         end
         DATA: begin
            if (tick) begin
               tc_d = tc_q + 4'd1;
               if (tc_q == TC_LAST) begin
                  shift_d = {rxs_q, shift_q[7:1]};
                  bit_d   = bit_q + 3'd1;
                  if (bit_q == BIT_LAST) begin
`ifdef UART_RX_PARITY_EN
                     state_d = PARITY;
`else
                     state_d = STOP;
`endif
                  end
               end
            end
         end
         PARITY: begin
`ifdef UART_RX_PARITY_EN
            if (tick) begin
               tc_d = tc_q + 4'd1;
               if (tc_q == TC_LAST) begin
                  if (((^shift_q) ^ rxs_q) != parity_odd) begin
                     pe_set = 1'b1;
                     bad_d  = 1'b1;
                  end
                  state_d = STOP;
               end
            end
`else
            state_d = IDLE;
`endif
         end
         STOP: begin
            if (tick) begin
               tc_d = tc_q + 4'd1;
               if (tc_q == TC_LAST) begin
                  if (rxs_q) begin
                     push_d  = ~bad_q;
                     state_d = IDLE;
                  end else begin
                     fe_set  = 1'b1;
                     state_d = BREAK;
                  end
               end
            end
         end
         BREAK: begin
            if (rxs_q) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase

      // Disabling aborts the frame outright, including a stop sample
      // that would otherwise land this cycle.
      if (!en) begin
         state_d = IDLE;
         push_d  = 1'b0;
         fe_set  = 1'b0;
`ifdef UART_RX_PARITY_EN
         pe_set  = 1'b0;
`endif
      end
   end

   // A push into a full FIFO is only lost when no pop frees a slot.
   assign ovr_set = push_q & full & ~rd;

   // Set beats clear when both happen together.
   always_comb begin
      overrun_d   = (overrun_q & ~clr_err) | ovr_set;
      frame_err_d = (frame_err_q & ~clr_err) | fe_set;
`ifdef UART_RX_PARITY_EN
      parity_err_d = (parity_err_q & ~clr_err) | pe_set;
`endif
   end

   always_ff @(posedge HCLK) begin
      if (HRESET) begin
         rx_meta_q   <= 1'b1;
         rxs_q       <= 1'b1;
         pcnt_q      <= '0;
         state_q     <= IDLE;
         tc_q        <= '0;
         bit_q       <= '0;
         shift_q     <= '0;
         bad_q       <= 1'b0;
         push_q      <= 1'b0;
         overrun_q   <= 1'b0;
         frame_err_q <= 1'b0;
`ifdef UART_RX_PARITY_EN
         parity_err_q <= 1'b0;
`endif
      end else begin
         rx_meta_q   <= rx;
         rxs_q       <= rx_meta_q;
         pcnt_q      <= pcnt_d;
         state_q     <= state_d;
         tc_q        <= tc_d;
         bit_q       <= bit_d;
         shift_q     <= shift_d;
         bad_q       <= bad_d;
         push_q      <= push_d;
         overrun_q   <= overrun_d;
         frame_err_q <= frame_err_d;
`ifdef UART_RX_PARITY_EN
         parity_err_q <= parity_err_d;
`endif
      end
   end

   // shift_q is stable until the next frame's DATA state, so it can
   // feed the FIFO directly on the registered push.
   sync_fifo #(
      .DEPTH (DEPTH),
      .WIDTH (8)
   ) u_fifo (
      .clk   (HCLK),
      .rst   (HRESET),
      .push  (push_q),
      .pop   (rd),
      .wdata (shift_q),
      .rdata (rdata),
      .empty (empty),
      .full  (full),
      .level (level)
   );

   assign overrun   = overrun_q;
   assign frame_err = frame_err_q;
`ifdef UART_RX_PARITY_EN
   assign parity_err = parity_err_q;
   assign irq = ~empty | overrun_q | frame_err_q | parity_err_q;
`else
   assign irq = ~empty | overrun_q | frame_err_q;
`endif

endmodule

// File: tb/tb_uart_rx_buf.sv
// tb_uart_rx_buf: serial-frame driver plus byte-queue reference
// model for uart_rx_buf.
`timescale 1ns/1ps
module tb_uart_rx_buf;

   localparam int DEPTH = 16;
   localparam int PSW   = 16;
   localparam int LW    = $clog2(DEPTH + 1);
`ifdef UART_RX_PARITY_EN
   localparam int NBITS = 11;
`else
   localparam int NBITS = 10;
`endif
   // Edge (counted from the start-bit drive) at which the byte enters
   // the FIFO at prescale=0: 2 sync stages, 1 cycle to leave IDLE,
   // tick 8 + 16 per remaining bit for the stop sample, then +1.
   localparam int PUSH_EDGE = 2 + 1 + 8 + 16 * (NBITS - 1) + 1;

   logic           HCLK = 1'b0;
   logic           HRESET;
   logic           en;
   logic [PSW-1:0] prescale;
   logic           rx;
   logic           rd;
   logic           clr_err;
   logic           parity_odd;
   logic [7:0]     rdata;
   logic           empty;
   logic           full;
   logic [LW-1:0]  level;
   logic           overrun;
   logic           frame_err;
   logic           irq;
   logic           parity_err;

   uart_rx_buf #(.DEPTH(DEPTH), .PSW(PSW)) dut (
      .HCLK       (HCLK),
      .HRESET     (HRESET),
      .en         (en),
      .prescale   (prescale),
      .rx         (rx),
      .rd         (rd),
      .clr_err    (clr_err),
`ifdef UART_RX_PARITY_EN
      .parity_odd (parity_odd),
      .parity_err (parity_err),
`endif
      .rdata      (rdata),
      .empty      (empty),
      .full       (full),
      .level      (level),
      .overrun    (overrun),
      .frame_err  (frame_err),
      .irq        (irq)
   );

`ifndef UART_RX_PARITY_EN
   assign parity_err = 1'b0;
`endif

   always #5 HCLK = ~HCLK;

   int checks = 0;
   int errors = 0;

   logic [7:0] mq[$];
   logic       m_ovr, m_fe, m_pe;

   typedef struct {
      logic [7:0] data;
      logic       stop;
      int         exp_level;
      logic       exp_fe;
      logic [7:0] exp_head;
   } vec_t;

   task automatic chk(string name, logic [31:0] got, logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h exp=%0h", name, got, exp);
      end
   endtask

   task automatic step();
      @(posedge HCLK);
      #1;
   endtask

   task automatic idle(int n);
      rx = 1'b1;
      repeat (n) step();
   endtask

   task automatic model_reset();
      mq.delete();
      m_ovr = 1'b0;
      m_fe  = 1'b0;
      m_pe  = 1'b0;
   endtask

   task automatic model_frame(logic [7:0] b, logic stop, logic par_ok,
                              logic rd_same);
      if (rd_same && mq.size() > 0) void'(mq.pop_front());
      if (!par_ok) m_pe = 1'b1;
      if (!stop) m_fe = 1'b1;
      if (stop && par_ok) begin
         if (mq.size() == DEPTH) m_ovr = 1'b1;
         else mq.push_back(b);
      end
   endtask

   task automatic check_all(string t);
      logic [7:0] h;
      h = (mq.size() > 0) ? mq[0] : 8'h00;
      chk({t, ".level"}, 32'(level), mq.size());
      chk({t, ".empty"}, 32'(empty), 32'(mq.size() == 0));
      chk({t, ".full"},  32'(full),  32'(mq.size() == DEPTH));
      chk({t, ".rdata"}, 32'(rdata), 32'(h));
      chk({t, ".ovr"},   32'(overrun),   32'(m_ovr));
      chk({t, ".fe"},    32'(frame_err), 32'(m_fe));
      chk({t, ".pe"},    32'(parity_err), 32'(m_pe));
      chk({t, ".irq"},   32'(irq),
          32'((mq.size() != 0) | m_ovr | m_fe | m_pe));
   endtask

   function automatic logic [NBITS-1:0] frame_bits(logic [7:0] b,
                                                   logic stop, logic par);
      logic [NBITS-1:0] f;
      f       = '0;
      f[8:1]  = b;
      f[9]    = par;
      f[NBITS-1] = stop;
      return f;
   endfunction

   // Drives one whole frame; reports the edge at which empty fell.
   task automatic send_frame(logic [7:0] b, logic stop, logic bad_par,
                             int bitclk, int rd_edge, output int fall);
      logic [NBITS-1:0] f;
      logic was_empty;
      f = frame_bits(b, stop, (^b) ^ parity_odd ^ bad_par);
      fall = -1;
      was_empty = empty;
      for (int k = 0; k < NBITS * bitclk; k++) begin
         rx = f[k / bitclk];
         rd = (k + 1 == rd_edge);
         step();
         if (fall < 0 && was_empty && !empty) fall = k + 1;
      end
      rd = 1'b0;
      model_frame(b, stop, !bad_par, rd_edge > 0);
   endtask

   task automatic send_partial(logic [7:0] b, int ncyc);
      logic [NBITS-1:0] f;
      f = frame_bits(b, 1'b1, (^b) ^ parity_odd);
      for (int k = 0; k < ncyc; k++) begin
         rx = f[k / 16];
         step();
      end
   endtask

   task automatic pop(string t);
      chk({t, ".head"}, 32'(rdata),
          32'((mq.size() > 0) ? mq[0] : 8'h00));
      rd = 1'b1;
      step();
      rd = 1'b0;
      if (mq.size() > 0) void'(mq.pop_front());
   endtask

   task automatic clear_flags();
      clr_err = 1'b1;
      step();
      clr_err = 1'b0;
      m_ovr = 1'b0;
      m_fe  = 1'b0;
      m_pe  = 1'b0;
   endtask

   vec_t vecs[6];
   int   fall;

   initial begin
      vecs[0] = '{8'h5A, 1'b1, 1, 1'b0, 8'h5A};
      vecs[1] = '{8'h00, 1'b1, 2, 1'b0, 8'h5A};
      vecs[2] = '{8'hFF, 1'b1, 3, 1'b0, 8'h5A};
      vecs[3] = '{8'h96, 1'b0, 3, 1'b1, 8'h5A};
      vecs[4] = '{8'hA5, 1'b1, 4, 1'b1, 8'h5A};
      vecs[5] = '{8'h01, 1'b1, 5, 1'b1, 8'h5A};

      HRESET = 1'b1; en = 1'b1; prescale = '0; rx = 1'b1;
      rd = 1'b0; clr_err = 1'b0; parity_odd = 1'b0;
      model_reset();
      repeat (3) step();
      HRESET = 1'b0;
      check_all("reset");
      idle(5);

      // single byte with latency
      send_frame(8'h41, 1'b1, 1'b0, 16, 0, fall);
      chk("single.fall", fall, PUSH_EDGE);
      chk("single.rdata", 32'(rdata), 32'h41);
      chk("single.irq", 32'(irq), 1);
      check_all("single");
      pop("single");
      chk("single.empty", 32'(empty), 1);
      chk("single.irq0", 32'(irq), 0);

      // glitch
      rx = 1'b0;
      repeat (5) step();
      idle(60);
      check_all("glitch");

      // table
      for (int i = 0; i < 6; i++) begin
         send_frame(vecs[i].data, vecs[i].stop, 1'b0, 16, 0, fall);
         idle(vecs[i].stop ? 10 : 40);
         chk($sformatf("vec%0d.level", i), 32'(level), vecs[i].exp_level);
         chk($sformatf("vec%0d.fe", i), 32'(frame_err), 32'(vecs[i].exp_fe));
         chk($sformatf("vec%0d.head", i), 32'(rdata), 32'(vecs[i].exp_head));
      end
      while (mq.size() > 0) pop("vecdrain");
      clear_flags();
      check_all("vecclr");

      // framing / break
      send_frame(8'h55, 1'b0, 1'b0, 16, 0, fall);
      repeat (400) step();
      chk("brk.fe", 32'(frame_err), 1);
      chk("brk.level", 32'(level), 0);
      idle(20);
      send_frame(8'hA5, 1'b1, 1'b0, 16, 0, fall);
      idle(4);
      chk("brk.rdata", 32'(rdata), 32'hA5);
      chk("brk.level1", 32'(level), 1);
      clear_flags();
      chk("brk.clr", 32'(frame_err), 0);
      pop("brk");
      check_all("brk");

      // overrun at boundary
      for (int i = 0; i <= DEPTH; i++) begin
         send_frame(8'(i), 1'b1, 1'b0, 16, 0, fall);
      end
      idle(4);
      chk("ovr.level", 32'(level), DEPTH);
      chk("ovr.full", 32'(full), 1);
      chk("ovr.flag", 32'(overrun), 1);
      for (int i = 0; i < DEPTH; i++) begin
         chk($sformatf("ovr.pop%0d", i), 32'(rdata), i);
         pop("ovr");
      end
      clear_flags();
      check_all("ovr.clr");
      for (int i = 0; i < DEPTH; i++) begin
         send_frame(8'(i), 1'b1, 1'b0, 16, 0, fall);
      end
      send_frame(8'h10, 1'b1, 1'b0, 16, PUSH_EDGE, fall);
      idle(4);
      chk("ovr2.flag", 32'(overrun), 0);
      chk("ovr2.level", 32'(level), DEPTH);
      chk("ovr2.head", 32'(rdata), 32'h01);
      check_all("ovr2");
      while (mq.size() > 0) pop("ovr2");

      // reset mid-frame
      send_frame(8'h11, 1'b1, 1'b0, 16, 0, fall);
      idle(4);
      send_partial(8'h3C, 88);
      HRESET = 1'b1;
      rx = 1'b1;
      step();
      HRESET = 1'b0;
      model_reset();
      check_all("rstmid");
      idle(200);
      check_all("rstmid.after");

      // enable drop mid-frame
      send_frame(8'h22, 1'b1, 1'b0, 16, 0, fall);
      idle(4);
      send_partial(8'h3C, 88);
      en = 1'b0;
      rx = 1'b1;
      step();
      en = 1'b1;
      idle(200);
      check_all("en");
      chk("en.rdata", 32'(rdata), 32'h22);
      pop("en");
      chk("en.empty", 32'(empty), 1);

      // baud scaling
      prescale = 16'd9;
      send_frame(8'hC3, 1'b1, 1'b0, 160, 0, fall);
      idle(4);
      chk("baud.rdata", 32'(rdata), 32'hC3);
      check_all("baud");
      pop("baud");
      prescale = '0;

`ifdef UART_RX_PARITY_EN
      parity_odd = 1'b0;
      send_frame(8'hC3, 1'b1, 1'b1, 16, 0, fall);
      idle(4);
      chk("par.err", 32'(parity_err), 1);
      chk("par.level", 32'(level), 0);
      check_all("par");
      clear_flags();
`endif

      // randomized frames against the queue model
      for (int i = 0; i < 40; i++) begin
         logic [7:0] b;
         logic       st;
         int         p;
         b  = 8'($urandom);
         st = ($urandom_range(0, 7) != 0);
         p  = $urandom_range(0, 3);
         prescale = PSW'(p);
         send_frame(b, st, 1'b0, 16 * (p + 1), 0, fall);
         idle(st ? 8 : 30);
         check_all($sformatf("rnd%0d", i));
         repeat ($urandom_range(0, 1)) pop("rnd");
         if ($urandom_range(0, 5) == 0) clear_flags();
      end
      check_all("rnd.end");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
